// File: rtl/ram_responder.sv
// Four-phase request/acknowledge responder in front of a single-port synchronous RAM.
// Optional feature: define RAM_BOUNDS_CHECK_EN to reject out-of-range addresses and flag them in ram_stat.
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif

module ram_responder #(
    parameter int word_width = 32,
    parameter int ADDR_BITS  = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] ram_ctrl,
    output logic [word_width-1:0] ram_stat,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] data_in,
    output logic [word_width-1:0] data_out,
    output logic [1:0]            state_dbg
);

    // Handshake: the initiator raises READ or WRITE while ACK=0; ACK rises when the
    // access is done and falls only after both pins are sampled low again.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] ACKED = 2'd2;

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [word_width-1:0] mem [DEPTH];

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  ack_q;
    logic                  err_q;
    logic                  is_write;
    logic [word_width-1:0] addr_q;
    logic [word_width-1:0] data_q;
    logic [ADDR_BITS-1:0]  idx;
    logic                  in_range;
    logic                  rd_pin;
    logic                  wr_pin;
    logic                  access;
    logic                  unused_inputs;

    assign rd_pin        = ram_ctrl[`RAM_READ_PIN];
    assign wr_pin        = ram_ctrl[`RAM_WRITE_PIN];
    assign idx           = addr_q[ADDR_BITS-1:0];
    assign access        = (state == BUSY) && (cnt == 4'd0);
    assign state_dbg     = state;
    assign unused_inputs = ^{ram_ctrl, addr_q};

`ifdef RAM_BOUNDS_CHECK_EN
    assign in_range = ((addr_q >> ADDR_BITS) == '0);
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        ram_stat            = '0;
        ram_stat[`RAM_ACK]  = ack_q;
`ifdef RAM_BOUNDS_CHECK_EN
        ram_stat[`RAM_ACK+1] = err_q;
`endif
    end

    // Storage has no reset so it maps onto a plain synchronous RAM; a reset during
    // BUSY forces state to IDLE asynchronously, which also suppresses this write.
    always_ff @(posedge clk) begin
        if (access && is_write && in_range) begin
            mem[idx] <= data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            is_write <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_pin || wr_pin) begin
                        addr_q   <= addr;
                        data_q   <= data_in;
                        is_write <= wr_pin;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ack_q <= 1'b1;
                        err_q <= ~in_range;
                        if (!is_write) begin
                            data_out <= in_range ? mem[idx] : '0;
                        end
                        state <= ACKED;
                    end
                end
                ACKED: begin
                    if (!rd_pin && !wr_pin) begin
                        ack_q <= 1'b0;
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
